ppcm_arbiter: RTL

- Two-port arbiter sharing one parallel PCM core read interface (cs/addr/burst/dout/busy/ack) between requesters.
- Port 0 is the wishbone memory adapter path. Port 1 is the boot/prefetch engine, which copies PCM images into RAM.
- Sits between the requesters and ppcm_core_nexys3.
- Round-robin grant with burst locking. A transaction is never split or interleaved on the core.

---
 rtl/ppcm_arbiter_pkg.sv | 13 +
 rtl/ppcm_arbiter_rr_pick2.sv | 20 ++
 rtl/ppcm_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ppcm_arbiter_pkg.sv
// Shared types and constants for the two-port parallel PCM arbiter.
package ppcm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic PORT_WB   = 1'b0;
  localparam logic PORT_BOOT = 1'b1;

endpackage

// File: rtl/ppcm_arbiter_rr_pick2.sv
// Two-way round-robin select: on a tie the port that did not own the core last wins.
module ppcm_arbiter_rr_pick2
  import ppcm_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic pick
);

  always_comb begin
    pick = PORT_WB;
    if (req0 && req1) begin
      pick = ~last_owner;
    end else if (req1) begin
      pick = PORT_BOOT;
    end
  end

endmodule

// File: rtl/ppcm_arbiter.sv
// Shares one PCM core read interface between the wishbone adapter (port 0) and the
// boot/prefetch engine (port 1); a granted transaction runs to completion uninterrupted.
module ppcm_arbiter
  import ppcm_arbiter_pkg::*;
#(
  parameter int ADDR_BITS     = 24,
  parameter int BEAT_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_cs,
  input  logic [ADDR_BITS-3:0]     req0_addr,
  input  logic                     req0_burst,
  output logic [31:0]              req0_dout,
  output logic                     req0_ack,
  output logic                     req0_gnt,
  input  logic                     req1_cs,
  input  logic [ADDR_BITS-3:0]     req1_addr,
  input  logic                     req1_burst,
  output logic [31:0]              req1_dout,
  output logic                     req1_ack,
  output logic                     req1_gnt,
  output logic                     core_cs,
  output logic [ADDR_BITS-3:0]     core_addr,
  output logic                     core_burst,
  input  logic [31:0]              core_dout,
  input  logic                     core_busy,
  input  logic                     core_ack,
  output logic                     arb_busy,
  output logic [BEAT_CNT_BITS-1:0] beat_cnt,
  output arb_state_e               state_dbg
);

  // Handshake: a requester raises reqN_cs and holds it, with addr/burst stable, until
  // after its final reqN_ack; reqN_gnt marks ownership, reqN_ack qualifies reqN_dout.

  arb_state_e               state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [BEAT_CNT_BITS-1:0] beat_q, beat_d;

  logic pick;
  logic owner_cs;
  logic in_grant;
  logic ack_hit;

  ppcm_arbiter_rr_pick2 u_pick (
    .req0       (req0_cs),
    .req1       (req1_cs),
    .last_owner (last_q),
    .pick       (pick)
  );

  always_comb begin
    owner_cs = owner_q ? req1_cs : req0_cs;
    in_grant = (state_q == ARB_GRANT);
    ack_hit  = in_grant & core_ack;

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;

    case (state_q)
      ARB_IDLE: begin
        if ((req0_cs || req1_cs) && !core_busy) begin
          state_d = ARB_GRANT;
          owner_d = pick;
          beat_d  = '0;
          gnt_d   = pick ? 2'b10 : 2'b01;
        end
      end
      ARB_GRANT: begin
        if (ack_hit && (beat_q != {BEAT_CNT_BITS{1'b1}})) begin
          beat_d = beat_q + 1'b1;
        end
        if (!owner_cs) begin
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        // Wait for the core to finish its cycle before anyone else may start.
        if (!core_busy) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= PORT_WB;
      last_q  <= PORT_BOOT;
      gnt_q   <= 2'b00;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
    end
  end

  // Core request lines follow the owner combinationally so cs drops with the owner's cs.
  always_comb begin
    core_cs    = in_grant & owner_cs;
    core_addr  = in_grant ? (owner_q ? req1_addr : req0_addr) : '0;
    core_burst = in_grant & (owner_q ? req1_burst : req0_burst);
    req0_ack   = ack_hit & ~owner_q;
    req1_ack   = ack_hit & owner_q;
    req0_gnt   = gnt_q[0];
    req1_gnt   = gnt_q[1];
    req0_dout  = gnt_q[0] ? core_dout : 32'd0;
    req1_dout  = gnt_q[1] ? core_dout : 32'd0;
    arb_busy   = (state_q != ARB_IDLE);
    beat_cnt   = beat_q;
    state_dbg  = state_q;
  end

endmodule
